alu_seq_ctrl: RTL
=================

# alu_seq_ctrl

- Front-panel sequencer for the ALU datapath.
- Collects operand A, operand B and an opcode as serially entered bits from push buttons.
- Issues a one-cycle start to the ALU and waits for its done handshake, with a timeout.
- Latches the result for display; sits between the button inputs and the ALU/seven-segment logic in `top`.

## Interface
- WIDTH, 8, operand and result width in bits (≥2)
- OPW, 3, opcode width in bits (≥1)
- TIMEOUT, 255, maximum WAIT cycles before the done handshake is abandoned (≥1)

- hz100  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- btn0  in  1  button level; rising edge enters a 0 bit
- btn1  in  1  button level; rising edge enters a 1 bit
- btn_next  in  1  button level; rising edge advances the sequence
- btn_clr  in  1  button level; rising edge clears the current entry field
- alu_done  in  1  ALU completion, sampled only in WAIT
- alu_result  in  WIDTH  ALU output, sampled with alu_done
- alu_a  out  WIDTH  operand A register
- alu_b  out  WIDTH  operand B register
- alu_op  out  OPW  opcode register
- alu_start  out  1  one-cycle start pulse
- result  out  WIDTH  latched result
- err  out  1  set on timeout; sticky until the next ENTER_A entry
- busy  out  1  high in START or WAIT
- state  out  3  current state encoding

## Operation
- Each button has a previous-level register, reset to 0, and pulse = level & ~prev.
- Because prev resets to 0, a button held through reset deassertion produces exactly one pulse.
- States and encodings: ENTER_A=0, ENTER_B=1, ENTER_OP=2, START=3, WAIT=4, SHOW=5. Codes 6 and 7 are illegal and go to ENTER_A on the next edge.
- Current field: alu_a in ENTER_A, alu_b in ENTER_B, alu_op in ENTER_OP.
- Bit entry in ENTER_*: field <= {field[MSB-1:0], bit}. Bits shifted past the MSB are discarded.
- btn0 and btn1 pulsing in the same cycle: no shift.
- Clear in ENTER_*: a clr pulse zeroes the current field. Clear beats any bit pulse and any next pulse in the same cycle.
- Advance on next: ENTER_A -> ENTER_B -> ENTER_OP -> START.
- A bit pulse and a next pulse in the same cycle both take effect: the bit goes into the old field, then the state advances.
- START always -> WAIT after one cycle. alu_start = 1 only in START.
- In WAIT:
  - alu_done = 1: capture result <= alu_result, err <= 0, go to SHOW.
  - Otherwise the timeout counter increments. When TIMEOUT consecutive WAIT cycles pass without done: result <= 0, err <= 1, go to SHOW.
  - If done arrives on the cycle the timeout would fire, done wins.
- SHOW + next -> ENTER_A. On that transition alu_a, alu_b, alu_op and err clear to 0; result holds.
- Button pulses in START, WAIT and SHOW are ignored, except next in SHOW.
- alu_done outside WAIT is ignored.
- Reset values: state=ENTER_A, alu_a=0, alu_b=0, alu_op=0, alu_start=0, result=0, err=0, busy=0, timeout counter=0, all prev registers=0.

## Timing
- A button rising before edge k is acted on at edge k; the field or state change is visible after edge k (1-cycle latency).
- alu_a, alu_b and alu_op are stable from START through WAIT and SHOW. The ALU may sample them on any of those cycles.
- alu_start is high for exactly one cycle, the cycle after the edge that accepted next in ENTER_OP.
- The timeout counter clears on entry to WAIT.
- WAIT lasts at most TIMEOUT cycles. Done in WAIT cycle n, with 1 ≤ n ≤ TIMEOUT, gives SHOW after that edge.
- result and err update on the edge that leaves WAIT.
- Asynchronous reset at any time, including mid-WAIT, forces all reset values immediately. alu_start drops without waiting for the clock, and a late alu_done is ignored.

## Test plan
- Reset, then pulse btn1, btn0, btn1 -> alu_a = 8'h05, state = 0.
- Enter A = 8'h03, next, B = 8'h0A, next, op = 3'b010, next -> alu_start high for 1 cycle with alu_a=03, alu_b=0A, alu_op=2, busy=1. Return alu_done with alu_result = 8'h0D two cycles later -> result=0D, err=0, state=5. Next -> state=0, alu_a=0, result=0D.
- Reach WAIT with alu_done held 0 and TIMEOUT=4 -> exactly 4 WAIT cycles, then state=5, result=0, err=1.
- Same setup, with done asserted in WAIT cycle 4 -> result captured, err=0.
- Same-cycle events in ENTER_B with B=8'h0F:
  - clr + btn1 + next -> B=0, state stays 1.
  - btn0 + btn1 -> B unchanged.
  - btn1 + next -> B=8'h1F, state=2.
- Assert reset mid-WAIT -> all outputs 0 and state=0 immediately. Hold btn_next high through reset release -> one advance to state=1 on the first edge.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: front-panel sequencer for the ALU datapath.
// Operands A, B and the opcode are shifted in one bit at a time from push
// buttons. The block then pulses alu_start and waits for alu_done, giving up
// after TIMEOUT cycles. The result (or 0 plus err on timeout) is held for display.
module alu_seq_ctrl #(
  parameter int WIDTH   = 8,
  parameter int OPW     = 3,
  parameter int TIMEOUT = 255
) (
  input  logic             hz100,
  input  logic             reset,
  input  logic             btn0,
  input  logic             btn1,
  input  logic             btn_next,
  input  logic             btn_clr,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  output logic             alu_start,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy,
  output logic [2:0]       state
);

  localparam logic [2:0] S_ENTER_A  = 3'd0;
  localparam logic [2:0] S_ENTER_B  = 3'd1;
  localparam logic [2:0] S_ENTER_OP = 3'd2;
  localparam logic [2:0] S_START    = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_SHOW     = 3'd5;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // Button index order in the edge-detect vectors: {clr, next, one, zero}
  logic [3:0]       btn_vec;
  logic [3:0]       prev_reg;
  logic [3:0]       pulse;
  logic             bit_en;
  logic             bit_val;

  logic [2:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [OPW-1:0]   op_reg, op_next;
  logic [WIDTH-1:0] result_reg, result_next;
  logic             err_reg, err_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [OPW-1:0]   op_shift;

  assign btn_vec = {btn_clr, btn_next, btn1, btn0};
  assign pulse   = btn_vec & ~prev_reg;
  // Simultaneous 0 and 1 pulses are ambiguous, so neither is entered.
  assign bit_en  = pulse[0] ^ pulse[1];
  assign bit_val = pulse[1];

  assign a_shift = {a_reg[WIDTH-2:0], bit_val};
  assign b_shift = {b_reg[WIDTH-2:0], bit_val};

  // A one-bit opcode has no lower bits to keep; the new bit replaces it.
  generate
    if (OPW > 1) begin : g_op_wide
      assign op_shift = {op_reg[OPW-2:0], bit_val};
    end else begin : g_op_narrow
      assign op_shift = bit_val;
    end
  endgenerate

  // Next-state and register-update decode for entry, handshake and display.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    result_next = result_reg;
    err_next    = err_reg;
    cnt_next    = cnt_reg;
    case (state_reg)
      S_ENTER_A: begin
        if (pulse[3]) begin
          a_next = '0;
        end else begin
          if (bit_en) a_next = a_shift;
          if (pulse[2]) state_next = S_ENTER_B;
        end
      end
      S_ENTER_B: begin
        if (pulse[3]) begin
          b_next = '0;
        end else begin
          if (bit_en) b_next = b_shift;
          if (pulse[2]) state_next = S_ENTER_OP;
        end
      end
      S_ENTER_OP: begin
        if (pulse[3]) begin
          op_next = '0;
        end else begin
          if (bit_en) op_next = op_shift;
          if (pulse[2]) state_next = S_START;
        end
      end
      S_START: begin
        cnt_next   = '0;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          result_next = alu_result;
          err_next    = 1'b0;
          state_next  = S_SHOW;
        end else if (cnt_reg == CNT_LAST) begin
          result_next = '0;
          err_next    = 1'b1;
          state_next  = S_SHOW;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_SHOW: begin
        if (pulse[2]) begin
          a_next     = '0;
          b_next     = '0;
          op_next    = '0;
          err_next   = 1'b0;
          state_next = S_ENTER_A;
        end
      end
      default: begin
        state_next = S_ENTER_A;
      end
    endcase
  end

  // State and datapath registers; reset takes effect without waiting for hz100.
  always_ff @(posedge hz100 or posedge reset) begin
    if (reset) begin
      prev_reg   <= '0;
      state_reg  <= S_ENTER_A;
      a_reg      <= '0;
      b_reg      <= '0;
      op_reg     <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      prev_reg   <= btn_vec;
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      op_reg     <= op_next;
      result_reg <= result_next;
      err_reg    <= err_next;
      cnt_reg    <= cnt_next;
    end
  end

  // alu_start and busy decode straight from state, so reset drops them at once.
  assign alu_start = (state_reg == S_START);
  assign busy      = (state_reg == S_START) || (state_reg == S_WAIT);
  assign state     = state_reg;
  assign alu_a     = a_reg;
  assign alu_b     = b_reg;
  assign alu_op    = op_reg;
  assign result    = result_reg;
  assign err       = err_reg;

endmodule
